// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main-control FSM sequencing the multicycle MIPS datapath
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctrl,
  output logic       illegal_op,
  output logic [3:0] count_state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC = 4'd3, MEM_WB = 4'd4, MEM2 = 4'd5, HALT = 4'd15
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LUI = 6'h0F, OP_LW = 6'h23,
                         OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_SLT = 6'h2A, F_SLL = 6'h00;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110,
                         A_SLT = 4'b0111, A_SLL = 4'b1000, A_LUI = 4'b1001;
  state_t     state;
  logic [5:0] op_r, fn_r;
  logic       ok, is_mem;
  logic [3:0] r_alu;
  // decode legality uses the live IR fields; later states use the copies latched in DECODE
  assign ok = (opcode == OP_R) ? (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL})
                               : (opcode inside {OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J});
  assign is_mem = (op_r == OP_LW) || (op_r == OP_SW);
  assign r_alu = (fn_r == F_SUB) ? A_SUB :
                 (fn_r == F_AND) ? A_AND :
                 (fn_r == F_OR)  ? A_OR  :
                 (fn_r == F_SLT) ? A_SLT :
                 (fn_r == F_SLL) ? A_SLL : A_ADD;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_r  <= '0;
      fn_r  <= '0;
    end else begin
      if (state == DECODE) begin
        op_r <= opcode;
        fn_r <= funct;
      end
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   state <= DECODE;
        DECODE:  state <= ok ? EXEC : HALT;
        EXEC:    state <= (op_r == OP_BEQ || op_r == OP_J) ? FETCH : MEM_WB;
        MEM_WB:  state <= is_mem ? MEM2 : FETCH;
        MEM2:    state <= FETCH;
        default: state <= HALT;
      endcase
    end
  end
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = A_ADD;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      DECODE: alu_src_b = 2'b11;
      EXEC: begin
        if (op_r == OP_J) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end else if (op_r == OP_LUI) begin
          alu_src_b = 2'b10;
          alu_ctrl  = A_LUI;
        end else if (op_r == OP_R) begin
          alu_src_a = 1'b1;
          alu_ctrl  = r_alu;
        end else if (op_r == OP_BEQ) begin
          alu_src_a = 1'b1;
          alu_ctrl  = A_SUB;
          branch    = 1'b1;
          pc_src    = 2'b01;
        end else begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
      end
      MEM_WB: begin
        iord      = is_mem;
        mem_write = op_r == OP_SW;
        reg_write = !is_mem;
        reg_dst   = op_r == OP_R;
      end
      MEM2: begin
        mem_to_reg = op_r == OP_LW;
        reg_write  = op_r == OP_LW;
      end
      HALT: illegal_op = 1'b1;
      default: ;
    endcase
  end
  assign pc_en       = pc_write | (branch & zero);
  assign count_state = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven check of the multicycle control FSM
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       pc_write, branch, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_ctrl, count_state;
  logic       illegal_op;
  int         checks = 0, errors = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .branch(branch), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
    .illegal_op(illegal_op), .count_state(count_state)
  );

  always #5 clk = ~clk;

  // sb = {pc_write, branch, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a}
  typedef struct {
    logic       rst;
    logic [5:0] op, fn;
    logic       z;
    logic [3:0] st;
    logic [9:0] sb;
    logic [1:0] srcb, pcs;
    logic [3:0] alu;
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000, OR_ = 4'b0001,
                         SLT = 4'b0111, SLL = 4'b1000, LUI = 4'b1001;

  task automatic v(input logic r, input logic [5:0] o, f, input logic z, input logic [3:0] s,
                   input logic [9:0] b, input logic [1:0] sb_, pc, input logic [3:0] a, input logic i);
    vec_t t;
    t.rst = r; t.op = o; t.fn = f; t.z = z; t.st = s; t.sb = b; t.srcb = sb_; t.pcs = pc; t.alu = a; t.ill = i;
    vecs.push_back(t);
  endtask

  task automatic fd(input logic [5:0] o, f, input logic z);
    v(0, o, f, z, 4'd1, 10'b1010010000, 2'b01, 2'b00, ADD, 0);
    v(0, o, f, z, 4'd2, 10'b0000000000, 2'b11, 2'b00, ADD, 0);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [3:0] a);
    fd(6'h00, f, 0);
    v(0, 6'h3F, 6'h00, 0, 4'd3, 10'b0000000001, 2'b00, 2'b00, a, 0);
    v(0, 6'h3F, 6'h00, 0, 4'd4, 10'b0000001010, 2'b00, 2'b00, ADD, 0);
  endtask

  task automatic chk(input string name, input logic [9:0] act, req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk("state", {6'b0, count_state}, {6'b0, e.st});
      chk("strobes", {pc_write, branch, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a}, e.sb);
      chk("srcb_pcsrc", {6'b0, alu_src_b, pc_src}, {6'b0, e.srcb, e.pcs});
      chk("illegal_op", {9'b0, illegal_op}, {9'b0, e.ill});
      if (e.st != 4'd0 && e.st != 4'd15)
        chk("alu_ctrl", {6'b0, alu_ctrl}, {6'b0, e.alu});
    end
  end

  initial begin
    // reset and idle
    v(1, 0, 0, 0, 4'd0, 10'b0, 2'b00, 2'b00, ADD, 0);
    v(1, 0, 0, 0, 4'd0, 10'b0, 2'b00, 2'b00, ADD, 0);
    v(0, 0, 0, 0, 4'd0, 10'b0, 2'b00, 2'b00, ADD, 0);
    // addi, lui, addi
    fd(6'h08, 6'h03, 0);
    v(0, 6'h08, 6'h03, 0, 4'd3, 10'b0000000001, 2'b10, 2'b00, ADD, 0);
    v(0, 6'h08, 6'h03, 0, 4'd4, 10'b0000000010, 2'b00, 2'b00, ADD, 0);
    fd(6'h0F, 6'h01, 0);
    v(0, 6'h0F, 6'h01, 0, 4'd3, 10'b0000000000, 2'b10, 2'b00, LUI, 0);
    v(0, 6'h0F, 6'h01, 0, 4'd4, 10'b0000000010, 2'b00, 2'b00, ADD, 0);
    fd(6'h08, 6'h01, 0);
    v(0, 6'h08, 6'h01, 0, 4'd3, 10'b0000000001, 2'b10, 2'b00, ADD, 0);
    v(0, 6'h08, 6'h01, 0, 4'd4, 10'b0000000010, 2'b00, 2'b00, ADD, 0);
    // sw then lw
    fd(6'h2B, 6'h00, 0);
    v(0, 6'h2B, 6'h00, 0, 4'd3, 10'b0000000001, 2'b10, 2'b00, ADD, 0);
    v(0, 6'h2B, 6'h00, 0, 4'd4, 10'b0001100000, 2'b00, 2'b00, ADD, 0);
    v(0, 6'h2B, 6'h00, 0, 4'd5, 10'b0000000000, 2'b00, 2'b00, ADD, 0);
    fd(6'h23, 6'h00, 0);
    v(0, 6'h23, 6'h00, 0, 4'd3, 10'b0000000001, 2'b10, 2'b00, ADD, 0);
    v(0, 6'h23, 6'h00, 0, 4'd4, 10'b0001000000, 2'b00, 2'b00, ADD, 0);
    v(0, 6'h23, 6'h00, 0, 4'd5, 10'b0000000110, 2'b00, 2'b00, ADD, 0);
    // beq taken / not taken, j
    fd(6'h04, 6'h00, 1);
    v(0, 6'h04, 6'h00, 1, 4'd3, 10'b0110000001, 2'b00, 2'b01, SUB, 0);
    fd(6'h04, 6'h00, 0);
    v(0, 6'h04, 6'h00, 0, 4'd3, 10'b0100000001, 2'b00, 2'b01, SUB, 0);
    fd(6'h02, 6'h00, 0);
    v(0, 6'h02, 6'h00, 0, 4'd3, 10'b1010000000, 2'b00, 2'b10, ADD, 0);
    // R-types; live opcode is garbage after DECODE
    rtype(6'h22, SUB);
    rtype(6'h20, ADD);
    rtype(6'h24, AND_);
    rtype(6'h25, OR_);
    rtype(6'h2A, SLT);
    rtype(6'h00, SLL);
    // illegal opcode halts for 10 cycles, reset recovers
    fd(6'h3F, 6'h00, 0);
    for (int i = 0; i < 10; i++) v(0, 6'h3F, 6'h00, 0, 4'd15, 10'b0, 2'b00, 2'b00, ADD, 1);
    v(1, 6'h3F, 6'h00, 0, 4'd15, 10'b0, 2'b00, 2'b00, ADD, 1);
    v(0, 0, 0, 0, 4'd0, 10'b0, 2'b00, 2'b00, ADD, 0);
    // illegal R funct
    fd(6'h00, 6'h3F, 0);
    v(0, 6'h00, 6'h3F, 0, 4'd15, 10'b0, 2'b00, 2'b00, ADD, 1);
    v(1, 6'h00, 6'h3F, 0, 4'd15, 10'b0, 2'b00, 2'b00, ADD, 1);
    v(0, 0, 0, 0, 4'd0, 10'b0, 2'b00, 2'b00, ADD, 0);
    // reset during lw MEM_WB: no reg_write afterwards, resumes at FETCH
    fd(6'h23, 6'h00, 0);
    v(0, 6'h23, 6'h00, 0, 4'd3, 10'b0000000001, 2'b10, 2'b00, ADD, 0);
    v(1, 6'h23, 6'h00, 0, 4'd4, 10'b0001000000, 2'b00, 2'b00, ADD, 0);
    v(0, 6'h23, 6'h00, 0, 4'd0, 10'b0000000000, 2'b00, 2'b00, ADD, 0);
    fd(6'h08, 6'h00, 0);
    v(0, 6'h08, 6'h00, 0, 4'd3, 10'b0000000001, 2'b10, 2'b00, ADD, 0);
    v(0, 6'h08, 6'h00, 0, 4'd4, 10'b0000000010, 2'b00, 2'b00, ADD, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset  = vecs[i].rst;
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      zero   = vecs[i].z;
      exp_q.push_back(vecs[i]);
    end
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
